alu_sequencer: RTL and testbench

- Multi-cycle control unit that drives the 8-bit ALU: accepts 16-bit instructions over a valid/ready handshake and decodes them into ALU operation code, operand-select flag and operands.
- Sequences the ALU operation, writes the result into a 4x8 register file and holds the zero flag.
- Sits between the instruction source and the ALU's `ALUControl`/`ALUFlagIn` inputs; consumes `ALU_Out` and the ALU zero output `C`.

---
 rtl/alu_pkg.sv | 99 +++++++++
 rtl/alu_regfile.sv | 46 ++++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: ALU codes, opcodes,
// FSM states, operand selects and the opcode decoder.
package alu_pkg;

    localparam int ADDR_W = 2;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SHR = 4'b0011;
    localparam logic [3:0] ALU_SHL = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_ROL = 4'b1000;
    localparam logic [3:0] ALU_ROR = 4'b1001;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_SHL = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_WB
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       use_alu;
        logic       wr_rd;
        logic [3:0] ctrl;
        logic [1:0] flag;
    } dec_t;

    // sel is instr[7]; it only matters for the unary ops.
    function automatic dec_t decode_op(input logic [3:0] op,
                                       input logic       sel);
        dec_t       d;
        logic [1:0] us;
        us = sel ? SEL_B : SEL_A;
        d.legal   = 1'b1;
        d.use_alu = 1'b1;
        d.wr_rd   = 1'b1;
        d.ctrl    = ALU_AND;
        d.flag    = SEL_A;
        case (op)
            OP_NOP: begin
                d.use_alu = 1'b0;
                d.wr_rd   = 1'b0;
            end
            OP_LDI: d.use_alu = 1'b0;
            OP_AND: d.ctrl = ALU_AND;
            OP_OR:  d.ctrl = ALU_OR;
            OP_ADD: d.ctrl = ALU_ADD;
            OP_SUB: d.ctrl = ALU_SUB;
            OP_XOR: d.ctrl = ALU_XOR;
            OP_SHR: begin
                d.ctrl = ALU_SHR;
                d.flag = us;
            end
            OP_SHL: begin
                d.ctrl = ALU_SHL;
                d.flag = us;
            end
            OP_NOT: begin
                d.ctrl = ALU_NOT;
                d.flag = us;
            end
            OP_ROL: d.ctrl = ALU_ROL;
            OP_ROR: d.ctrl = ALU_ROR;
            OP_CMP: begin
                d.ctrl  = ALU_SUB;
                d.wr_rd = 1'b0;
            end
            default: begin
                d.legal   = 1'b0;
                d.use_alu = 1'b0;
                d.wr_rd   = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: one write port, two read ports captured on re,
// one combinational debug read port. Async active-low reset.
module alu_regfile #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else if (re) begin
            rdata_a <= mem[raddr_a];
            rdata_b <= mem[raddr_b];
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 8-bit ALU: accepts instructions,
// decodes them, sequences the ALU, writes back to a 4x8 register file.
// Ports: instr_valid/instr/instr_ready handshake; alu_a/alu_b/alu_ctrl/
// alu_flag_in drive the ALU; alu_out/alu_zero come back; result,
// result_valid, zero_flag, err report status; dbg_addr/dbg_data peek rf.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int RF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    output logic [1:0]        alu_flag_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              zero_flag,
    output logic              err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t state, state_nx;

    logic [15:0]       instr_q;
    logic              cap_zero;
    dec_t              dec;
    logic [3:0]        op;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic              rf_we, rf_re;

    assign op  = instr_q[15:12];
    assign rd  = instr_q[11:10];
    assign rs1 = instr_q[9:8];
    assign rs2 = instr_q[7:6];
    assign dec = decode_op(op, instr_q[7]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        instr_ready  = 1'b0;
        result_valid = 1'b0;
        err          = 1'b0;
        unique case (state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = ST_DECODE;
            end
            ST_DECODE: begin
                if (!dec.legal) begin
                    err      = 1'b1;
                    state_nx = ST_IDLE;
                end else if (dec.use_alu) begin
                    state_nx = ST_EXEC;
                end else begin
                    state_nx = ST_WB;
                end
            end
            ST_EXEC: state_nx = ST_WB;
            ST_WB: begin
                result_valid = 1'b1;
                state_nx     = ST_IDLE;
            end
        endcase
    end

    // result is loaded on entry to WB so it is valid alongside
    // result_valid; the rf write and zero_flag land at the end of WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q     <= '0;
            alu_ctrl    <= '0;
            alu_flag_in <= '0;
            result      <= '0;
            cap_zero    <= 1'b0;
            zero_flag   <= 1'b0;
        end else begin
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == ST_DECODE && dec.use_alu) begin
                alu_ctrl    <= dec.ctrl;
                alu_flag_in <= dec.flag;
            end
            if (state == ST_DECODE && op == OP_LDI) begin
                result <= instr_q[DATA_W-1:0];
            end
            if (state == ST_EXEC) begin
                result   <= alu_out;
                cap_zero <= alu_zero;
            end
            if (state == ST_WB && dec.use_alu) begin
                zero_flag <= cap_zero;
            end
        end
    end

    assign rf_re = (state == ST_DECODE) && dec.use_alu;
    assign rf_we = (state == ST_WB) && dec.wr_rd;

    alu_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (RF_DEPTH),
        .AW     (ADDR_W)
    ) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (result),
        .re       (rf_re),
        .raddr_a  (rs1),
        .raddr_b  (rs2),
        .rdata_a  (alu_a),
        .rdata_b  (alu_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural ALU and
// a reference model of the instruction set.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_flag_in;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic [7:0]  result;
    logic        result_valid;
    logic        zero_flag;
    logic        err;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_rf [4];
    logic [7:0] ref_result;
    logic       ref_zero;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_ready  (instr_ready),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctrl     (alu_ctrl),
        .alu_flag_in  (alu_flag_in),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .result       (result),
        .result_valid (result_valid),
        .zero_flag    (zero_flag),
        .err          (err),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural ALU the sequencer drives.
    logic [7:0] alu_u;
    always_comb begin
        alu_u = (alu_flag_in == 2'b01) ? alu_b : alu_a;
        case (alu_ctrl)
            4'b0000: alu_out = alu_a & alu_b;
            4'b0001: alu_out = alu_a | alu_b;
            4'b0010: alu_out = alu_a + alu_b;
            4'b0110: alu_out = alu_a - alu_b;
            4'b0111: alu_out = alu_a ^ alu_b;
            4'b0011: alu_out = alu_u >> 1;
            4'b0100: alu_out = alu_u << 1;
            4'b0101: alu_out = ~alu_u;
            4'b1000: alu_out = {alu_a[6:0], alu_a[7]};
            4'b1001: alu_out = {alu_a[0], alu_a[7:1]};
            default: alu_out = 8'h00;
        endcase
    end
    assign alu_zero = (alu_out == 8'h00);

    function automatic logic [7:0] ref_exec(input logic [3:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic [7:0] u);
        int r;
        case (op)
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = (int'(a) + int'(b)) % 256;
            4'h5: r = (int'(a) - int'(b) + 256) % 256;
            4'h6: r = a ^ b;
            4'h7: r = int'(u) / 2;
            4'h8: r = (int'(u) * 2) % 256;
            4'h9: r = 255 - int'(u);
            4'hA: r = ((int'(a) * 2) % 256) + int'(a) / 128;
            4'hB: r = int'(a) / 2 + (int'(a) % 2) * 128;
            4'hC: r = (int'(a) - int'(b) + 256) % 256;
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    function automatic logic [3:0] ref_ctrl(input logic [3:0] op);
        case (op)
            4'h2: return 4'b0000;
            4'h3: return 4'b0001;
            4'h4: return 4'b0010;
            4'h5: return 4'b0110;
            4'h6: return 4'b0111;
            4'h7: return 4'b0011;
            4'h8: return 4'b0100;
            4'h9: return 4'b0101;
            4'hA: return 4'b1000;
            4'hB: return 4'b1001;
            4'hC: return 4'b0110;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op,
                                       input logic [1:0] rd,
                                       input logic [1:0] rs1,
                                       input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 6'b000000};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
        ref_result = 8'h00;
        ref_zero   = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            $display("FAIL wait_ready: instr_ready=%b required 1", instr_ready);
            errors++;
        end
        checks++;
    endtask

    task automatic exec_check(input logic [15:0] ins);
        logic [3:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] a, b, u, exp_res;
        logic [1:0] exp_flag;
        logic       is_alu, exp_zero, bad_ready;
        int         lat, exp_lat;
        op  = ins[15:12];
        rd  = ins[11:10];
        rs1 = ins[9:8];
        rs2 = ins[7:6];
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        u = ins[7] ? b : a;
        is_alu   = (op >= 4'h2) && (op <= 4'hC);
        exp_res  = (op == 4'h1) ? ins[7:0] :
                   is_alu ? ref_exec(op, a, b, u) : ref_result;
        exp_lat  = is_alu ? 3 : 2;
        exp_zero = is_alu ? (exp_res == 8'h00) : ref_zero;
        exp_flag = (op >= 4'h7 && op <= 4'h9) ? {1'b0, ins[7]} : 2'b00;

        wait_ready();
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        lat       = 1;
        bad_ready = 1'b0;
        while (!result_valid && lat < 8) begin
            if (instr_ready) bad_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat != exp_lat) begin
            $display("FAIL latency op=%h: got %0d required %0d", op, lat, exp_lat);
            errors++;
        end
        checks++;
        if (result !== exp_res) begin
            $display("FAIL result op=%h ins=%h: got %h required %h",
                     op, ins, result, exp_res);
            errors++;
        end
        checks++;
        if (bad_ready) begin
            $display("FAIL ready_busy op=%h: got 1 required 0", op);
            errors++;
        end
        checks++;
        if (is_alu) begin
            if (alu_ctrl !== ref_ctrl(op) || alu_flag_in !== exp_flag) begin
                $display("FAIL alu_ctrl op=%h: got %b/%b required %b/%b",
                         op, alu_ctrl, alu_flag_in, ref_ctrl(op), exp_flag);
                errors++;
            end
            checks++;
            if (alu_a !== a || alu_b !== b) begin
                $display("FAIL operands op=%h: got %h/%h required %h/%h",
                         op, alu_a, alu_b, a, b);
                errors++;
            end
            checks++;
        end

        if (op == 4'h1 || (is_alu && op != 4'hC)) ref_rf[rd] = exp_res;
        ref_zero   = exp_zero;
        ref_result = exp_res;

        @(posedge clk);
        #1;
        if (zero_flag !== ref_zero || result_valid !== 1'b0) begin
            $display("FAIL zero_flag op=%h: got z=%b rv=%b required z=%b rv=0",
                     op, zero_flag, result_valid, ref_zero);
            errors++;
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            if (dbg_data !== ref_rf[i]) begin
                $display("FAIL rf[%0d] after op=%h: got %h required %h",
                         i, op, dbg_data, ref_rf[i]);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 2'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if ({instr_ready, result_valid, err, zero_flag} !== 4'b1000 ||
            {alu_a, alu_b, alu_ctrl, alu_flag_in, result} !== 38'd0) begin
            $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b z=%b a=%h b=%h c=%b f=%b r=%h",
                     instr_ready, result_valid, err, zero_flag,
                     alu_a, alu_b, alu_ctrl, alu_flag_in, result);
            errors++;
        end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            if (dbg_data !== 8'h00) begin
                $display("FAIL reset_rf[%0d]: got %h required 00", i, dbg_data);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_directed();
        exec_check({4'h1, 2'd1, 2'd0, 8'h3C});
        exec_check({4'h1, 2'd2, 2'd0, 8'hC3});
        exec_check(mk(4'h4, 2'd3, 2'd1, 2'd2));
        exec_check(mk(4'hC, 2'd0, 2'd1, 2'd1));
        exec_check(mk(4'h7, 2'd0, 2'd0, 2'd2));
        exec_check(mk(4'h9, 2'd3, 2'd1, 2'd0));
        exec_check({4'h1, 2'd1, 2'd0, 8'h81});
        exec_check(mk(4'hA, 2'd2, 2'd1, 2'd0));
        exec_check(mk(4'hB, 2'd3, 2'd1, 2'd0));
        exec_check(mk(4'h0, 2'd1, 2'd2, 2'd3));
        exec_check(mk(4'h4, 2'd1, 2'd1, 2'd1));
    endtask

    task automatic test_illegal();
        logic [7:0] res_before;
        res_before = result;
        wait_ready();
        instr_valid = 1'b1;
        instr       = {4'hE, 12'($urandom)};
        @(posedge clk);
        #1;
        if (err !== 1'b1 || instr_ready !== 1'b0 || result_valid !== 1'b0) begin
            $display("FAIL illegal_decode: got err=%b rdy=%b rv=%b required 1/0/0",
                     err, instr_ready, result_valid);
            errors++;
        end
        checks++;
        @(negedge clk);
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        if (err !== 1'b0 || instr_ready !== 1'b1 || result !== res_before) begin
            $display("FAIL illegal_after: got err=%b rdy=%b r=%h required 0/1/%h",
                     err, instr_ready, result, res_before);
            errors++;
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            if (dbg_data !== ref_rf[i]) begin
                $display("FAIL illegal_rf[%0d]: got %h required %h",
                         i, dbg_data, ref_rf[i]);
                errors++;
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            exec_check({4'h1, 2'(i), 2'd0, 8'($urandom)});
        end
        for (int n = 0; n < 40; n++) begin
            exec_check({4'($urandom_range(0, 12)), 12'($urandom)});
        end
    endtask

    task automatic test_reset_mid();
        int seen_rv;
        exec_check({4'h1, 2'd1, 2'd0, 8'h5A});
        wait_ready();
        instr_valid = 1'b1;
        instr       = mk(4'h4, 2'd2, 2'd1, 2'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        if ({result_valid, err, zero_flag} !== 3'b000 ||
            {alu_a, alu_b, alu_ctrl, alu_flag_in, result} !== 38'd0) begin
            $display("FAIL reset_mid_outputs: got rv=%b err=%b z=%b a=%h b=%h c=%b f=%b r=%h",
                     result_valid, err, zero_flag,
                     alu_a, alu_b, alu_ctrl, alu_flag_in, result);
            errors++;
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1;
            if (dbg_data !== 8'h00) begin
                $display("FAIL reset_mid_rf[%0d]: got %h required 00", i, dbg_data);
                errors++;
            end
            checks++;
        end
        @(negedge clk);
        rst_n   = 1'b1;
        seen_rv = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (result_valid) seen_rv++;
        end
        if (seen_rv != 0 || instr_ready !== 1'b1) begin
            $display("FAIL reset_mid_release: got rv_count=%0d rdy=%b required 0/1",
                     seen_rv, instr_ready);
            errors++;
        end
        checks++;
        exec_check({4'h1, 2'd3, 2'd0, 8'h00});
        exec_check(mk(4'h6, 2'd0, 2'd3, 2'd3));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
